// File: rtl/serieaparalelo_pkg.sv
`default_nettype none
// ============================================================================
// Module : serieaparalelo_pkg
// Brief  : Shared serial-PHY constants: idle/comma symbol, lock depth, states.
// Rev    : 1.0  initial release
// ============================================================================
package serieaparalelo_pkg;

  localparam logic [7:0] COMMA      = 8'hBC;
  localparam int         SYNC_COUNT = 4;

  localparam int STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;
  localparam state_t ST_SEARCH = 2'd0;
  localparam state_t ST_ALIGN  = 2'd1;
  localparam state_t ST_ACTIVE = 2'd2;

  function automatic logic is_comma(input logic [7:0] b, input logic [7:0] sym);
    return (b == sym);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serieaparalelo_if.sv
`default_nettype none
// ============================================================================
// Module : serieaparalelo_if
// Brief  : Serial-in / byte-out bundle between the bit source and deserializer.
// Rev    : 1.0  initial release
// ============================================================================
interface serieaparalelo_if;

  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       byte_strobe;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active,
    input  byte_strobe
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active,
    output byte_strobe
  );

endinterface
`default_nettype wire

// File: rtl/serieaparalelo.sv
`default_nettype none
// ============================================================================
// Module : serieaparalelo
// Brief  : Comma-aligned MSB-first serial-to-parallel deserializer.
// Rev    : 1.0  initial release
// ============================================================================
module serieaparalelo
  import serieaparalelo_pkg::*;
#(
  parameter logic [7:0] COMMA_SYM = COMMA,
  parameter int         SYNC_N    = SYNC_COUNT
) (
  input  wire             clk_32f,
  input  wire             reset,
  serieaparalelo_if.slave bus
);

  localparam int BC_W = $clog2(SYNC_N + 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [6:0]      r_sr;
  logic [2:0]      r_bit_cnt;
  logic [2:0]      w_bit_cnt_nxt;
  logic [BC_W-1:0] r_bc_cnt;
  logic [BC_W-1:0] w_bc_cnt_nxt;
  logic [BC_W-1:0] w_bc_inc;
  logic [7:0]      r_data;
  logic [7:0]      w_data_nxt;
  logic            r_valid;
  logic            w_valid_nxt;
  logic            r_active;
  logic            w_active_nxt;
  logic            r_strobe;
  logic            w_strobe_nxt;

  logic [7:0]      w_cand;
  logic            w_hit;
  logic            w_byte_end;
  logic            w_locked;

  // Candidate includes the bit being sampled this cycle.
  assign w_cand     = {r_sr, bus.data_in};
  assign w_hit      = is_comma(w_cand, COMMA_SYM);
  assign w_byte_end = (r_bit_cnt == 3'd7);
  assign w_bc_inc   = (r_bc_cnt == BC_W'(SYNC_N)) ? r_bc_cnt : r_bc_cnt + BC_W'(1);
  assign w_locked   = (w_bc_inc == BC_W'(SYNC_N));

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_state   <= ST_SEARCH;
      r_sr      <= '0;
      r_bit_cnt <= '0;
      r_bc_cnt  <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_active  <= 1'b0;
      r_strobe  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sr      <= w_cand[6:0];
      r_bit_cnt <= w_bit_cnt_nxt;
      r_bc_cnt  <= w_bc_cnt_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_active  <= w_active_nxt;
      r_strobe  <= w_strobe_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SEARCH: if (w_hit) w_state_nxt = ST_ALIGN;
      ST_ALIGN: begin
        if (w_byte_end) begin
          if (!w_hit)        w_state_nxt = ST_SEARCH;
          else if (w_locked) w_state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: w_state_nxt = ST_ACTIVE;
      default:   w_state_nxt = ST_SEARCH;
    endcase
  end

  always_comb begin
    w_bit_cnt_nxt = r_bit_cnt;
    w_bc_cnt_nxt  = r_bc_cnt;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid;
    w_active_nxt  = r_active;
    w_strobe_nxt  = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        w_bit_cnt_nxt = '0;
        if (w_hit) w_bc_cnt_nxt = BC_W'(1);
      end
      ST_ALIGN: begin
        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
        if (w_byte_end) begin
          if (w_hit) begin
            w_bc_cnt_nxt = w_bc_inc;
            if (w_locked) w_active_nxt = 1'b1;
          end else begin
            w_bc_cnt_nxt = '0;
          end
        end
      end
      ST_ACTIVE: begin
        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
        if (w_byte_end) begin
          w_strobe_nxt = 1'b1;
          if (w_hit) begin
            w_valid_nxt = 1'b0;
          end else begin
            w_data_nxt  = w_cand;
            w_valid_nxt = 1'b1;
          end
        end
      end
      default: w_bit_cnt_nxt = '0;
    endcase
  end

  assign bus.data_out    = r_data;
  assign bus.valid_out   = r_valid;
  assign bus.active      = r_active;
  assign bus.byte_strobe = r_strobe;

endmodule
`default_nettype wire

// File: tb/tb_serieaparalelo.sv
`default_nettype none
// ============================================================================
// Module : tb_serieaparalelo
// Brief  : Directed bench for the comma-aligned deserializer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_serieaparalelo;

  logic clk_32f = 1'b0;
  logic reset   = 1'b1;
  int   n_chk   = 0;
  int   n_err   = 0;

  serieaparalelo_if bus ();

  serieaparalelo u_dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus.slave)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got=%02h want=%02h", tag, got, want);
    end
  endtask

  // Present one bit, let the next rising edge sample it, settle past the edge.
  task automatic send_bit(input logic b);
    bus.data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_first7(input logic [7:0] b);
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
  endtask

  task automatic pulse_reset(input logic b);
    reset = 1'b1;
    send_bit(b);
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".data"},   bus.data_out,           8'h00);
    check({tag, ".valid"},  {7'd0, bus.valid_out},  8'h00);
    check({tag, ".active"}, {7'd0, bus.active},     8'h00);
    check({tag, ".strobe"}, {7'd0, bus.byte_strobe}, 8'h00);
  endtask

  logic [7:0] lb_byte [20] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hDE, 8'hF0, 8'h0F, 8'hA5, 8'h3C,
                               8'h11, 8'h22, 8'hC3, 8'h7E, 8'h81, 8'hFF, 8'h00, 8'h5A, 8'hE7, 8'h6B};
  logic       lb_vld  [20] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                               1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    logic [7:0] exp_data;
    bus.data_in = 1'b1;

    // 1: reset held three cycles, then ones only
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    check_all_zero("rst");
    reset = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    check("ones.active", {7'd0, bus.active}, 8'h00);

    // 2: aligned commas from a clean state
    pulse_reset(1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    send_first7(8'hBC);
    check("lock.pre", {7'd0, bus.active}, 8'h00);
    send_bit(1'b0);
    check("lock.active", {7'd0, bus.active},    8'h01);
    check("lock.valid",  {7'd0, bus.valid_out}, 8'h00);
    check("lock.data",   bus.data_out,          8'h00);

    // 3: A5 then 3C
    send_first7(8'hA5);
    check("a5.pre.valid",  {7'd0, bus.valid_out},   8'h00);
    check("a5.pre.strobe", {7'd0, bus.byte_strobe}, 8'h00);
    send_bit(1'b1);
    check("a5.data",   bus.data_out,            8'hA5);
    check("a5.valid",  {7'd0, bus.valid_out},   8'h01);
    check("a5.strobe", {7'd0, bus.byte_strobe}, 8'h01);
    send_first7(8'h3C);
    check("a5.hold.data",   bus.data_out,            8'hA5);
    check("a5.hold.valid",  {7'd0, bus.valid_out},   8'h01);
    check("a5.hold.strobe", {7'd0, bus.byte_strobe}, 8'h00);
    send_bit(1'b0);
    check("3c.data",   bus.data_out,            8'h3C);
    check("3c.strobe", {7'd0, bus.byte_strobe}, 8'h01);
    send_byte(8'hBC);
    check("idle.valid", {7'd0, bus.valid_out}, 8'h00);
    check("idle.data",  bus.data_out,          8'h3C);

    // 4: three junk bits shift alignment by three cycles
    pulse_reset(1'b0);
    check_all_zero("rst4");
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    send_first7(8'hBC);
    check("junk.pre", {7'd0, bus.active}, 8'h00);
    send_bit(1'b0);
    check("junk.active", {7'd0, bus.active}, 8'h01);

    // 5: broken comma run forces a fresh count
    pulse_reset(1'b0);
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h00);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    check("break.active3", {7'd0, bus.active}, 8'h00);
    send_byte(8'hBC);
    check("break.active4", {7'd0, bus.active}, 8'h01);

    // 6: reset in the middle of a data byte
    send_byte(8'h3C);
    check("mid.data", bus.data_out, 8'h3C);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    pulse_reset(1'b0);
    check_all_zero("mid.rst");
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    check("relock.pre", {7'd0, bus.active}, 8'h00);
    send_byte(8'hBC);
    check("relock.active", {7'd0, bus.active}, 8'h01);

    // 7: transmitter model inserts commas on idle slots
    exp_data = 8'h00;
    for (int i = 0; i < 20; i++) begin
      send_byte(lb_vld[i] ? lb_byte[i] : 8'hBC);
      if (lb_vld[i]) exp_data = lb_byte[i];
      check($sformatf("lb%0d.valid", i), {7'd0, bus.valid_out}, {7'd0, lb_vld[i]});
      check($sformatf("lb%0d.data", i),  bus.data_out,          exp_data);
      check($sformatf("lb%0d.strobe", i), {7'd0, bus.byte_strobe}, 8'h01);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
